// File: rtl/case_sel_arbiter_ctrl.sv
// Arbiter that shares one 4-way case-decoded resource among 4 requesters.
// It grants in fixed-priority or round-robin order and holds each grant until done, request drop or timeout.
module case_sel_arbiter_ctrl #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_sel,
   output logic       gnt_valid,
   output logic       timeout_err
);

   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [1:0]    rr_ptr, rr_n;
   logic [3:0]    gnt_n;
   logic [1:0]    sel_n;
   logic          valid_n, to_n;

   logic [3:0]    rot;
   logic [2:0]    fix_pick, rr_pick;
   logic          win_valid;
   logic [1:0]    win_idx;

   // Returns {found, index} of the lowest set bit. An X or all-zero vector falls to "none".
   function automatic logic [2:0] first_set(input logic [3:0] v);
      logic [2:0] r;
      priority casez (v)
         4'b???1: r = 3'b100;
         4'b??10: r = 3'b101;
         4'b?100: r = 3'b110;
         4'b1000: r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

   // rot[k] is requester (rr_ptr+1+k) mod 4, so the search starts just past the last owner.
   always_comb begin
      rot = 4'b0000;
      unique case (rr_ptr)
         2'd0:    rot = {req[0], req[3], req[2], req[1]};
         2'd1:    rot = {req[1], req[0], req[3], req[2]};
         2'd2:    rot = {req[2], req[1], req[0], req[3]};
         2'd3:    rot = req;
         default: rot = 4'b0000;
      endcase
   end

   always_comb begin
      fix_pick  = first_set(req);
      rr_pick   = first_set(rot);
      win_valid = 1'b0;
      win_idx   = 2'd0;
      case (mode)
         1'b0: begin
            win_valid = fix_pick[2];
            win_idx   = fix_pick[1:0];
         end
         1'b1: begin
            win_valid = rr_pick[2];
            win_idx   = rr_ptr + 2'd1 + rr_pick[1:0];
         end
         default: begin
            win_valid = 1'b0;
            win_idx   = 2'd0;
         end
      endcase
   end

   always_comb begin
      state_n = state;
      hold_n  = hold_cnt;
      rr_n    = rr_ptr;
      gnt_n   = gnt;
      sel_n   = gnt_sel;
      valid_n = gnt_valid;
      to_n    = 1'b0;
      case (state)
         IDLE: begin
            if (win_valid) begin
               state_n = GRANT;
               gnt_n   = 4'b0001 << win_idx;
               sel_n   = win_idx;
               valid_n = 1'b1;
               hold_n  = '0;
            end
         end
         GRANT: begin
            hold_n = hold_cnt + HW'(1);
            if (done || !req[gnt_sel] || (hold_cnt == HOLD_LAST)) begin
               state_n = RELEASE;
               gnt_n   = 4'b0000;
               valid_n = 1'b0;
               hold_n  = '0;
               // done and request drop both take precedence over a simultaneous timeout
               to_n    = !done && req[gnt_sel] && (hold_cnt == HOLD_LAST);
            end
         end
         RELEASE: begin
            state_n = IDLE;
            rr_n    = gnt_sel;
         end
         default: begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         rr_ptr      <= 2'd3;
         gnt         <= 4'b0000;
         gnt_sel     <= 2'd0;
         gnt_valid   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_n;
         hold_cnt    <= hold_n;
         rr_ptr      <= rr_n;
         gnt         <= gnt_n;
         gnt_sel     <= sel_n;
         gnt_valid   <= valid_n;
         timeout_err <= to_n;
      end
   end

   a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
   a_valid_or:   assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
   a_sel_match:  assert property (@(posedge clk) disable iff (rst) gnt[gnt_sel] == gnt_valid);
   a_to_pulse:   assert property (@(posedge clk) disable iff (rst) timeout_err |=> !timeout_err);

endmodule

// File: tb/tb_case_sel_arbiter_ctrl.sv
// Bench for case_sel_arbiter_ctrl: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level model of owner, age and cooldown.
module tb_case_sel_arbiter_ctrl;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst;
   logic       mode;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic [1:0] gnt_sel;
   logic       gnt_valid;
   logic       timeout_err;

   int tests_run = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];

   case_sel_arbiter_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk(clk),
      .rst(rst),
      .mode(mode),
      .req(req),
      .done(done),
      .gnt(gnt),
      .gnt_sel(gnt_sel),
      .gnt_valid(gnt_valid),
      .timeout_err(timeout_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       mode;
      logic [3:0] req;
      logic       done;
      logic [3:0] exp_gnt;
      logic [1:0] exp_sel;
      logic       exp_valid;
      logic       exp_to;
   } vec_t;

   vec_t vecs[26];

   // reference model: who owns the resource, for how long, and how many dead cycles remain
   int m_owner;
   int m_age;
   int m_cool;
   int m_last;
   int m_sel;
   bit m_to;

   function automatic logic [7:0] pack_outs(logic [3:0] g, logic [1:0] s, logic v, logic t);
      return {g, s, v, t};
   endfunction

   task automatic drive(input logic r, input logic m, input logic [3:0] rq, input logic d);
      rst  = r;
      mode = m;
      req  = rq;
      done = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got gnt/sel/valid/to=%b expected %b", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [3:0] g, input logic [1:0] s,
                             input logic v, input logic t);
      check(name, pack_outs(gnt, gnt_sel, gnt_valid, timeout_err), pack_outs(g, s, v, t));
   endtask

   task automatic model_step(input logic r, input logic m, input logic [3:0] rq, input logic d);
      m_to = 1'b0;
      if (r) begin
         m_owner = -1;
         m_age   = 0;
         m_cool  = 0;
         m_last  = 3;
         m_sel   = 0;
      end else if (m_owner >= 0) begin
         if (d || !rq[m_owner] || m_age == MAX_HOLD) begin
            m_to    = !d && rq[m_owner] && (m_age == MAX_HOLD);
            m_last  = m_owner;
            m_owner = -1;
            m_cool  = 1;
         end else begin
            m_age++;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else begin
         for (int k = 0; k < 4; k++) begin
            int idx;
            idx = m ? (m_last + 1 + k) % 4 : k;
            if (m_owner < 0 && rq[idx]) begin
               m_owner = idx;
               m_age   = 1;
               m_sel   = idx;
            end
         end
      end
   endtask

   function automatic logic [7:0] model_outs();
      logic [3:0] g;
      g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      return pack_outs(g, 2'(m_sel), m_owner >= 0, m_to);
   endfunction

   // driver for model-checked cycles: apply, clock, predict, compare
   task automatic step(input logic r, input logic m, input logic [3:0] rq, input logic d);
      logic [7:0] e;
      drive(r, m, rq, d);
      @(posedge clk);
      model_step(r, m, rq, d);
      exp_q.push_back(model_outs());
      #1;
      e = exp_q.pop_front();
      check("random", pack_outs(gnt, gnt_sel, gnt_valid, timeout_err), e);
   endtask

   task automatic set_vec(input int i, input logic r, input logic m, input logic [3:0] rq,
                          input logic d, input logic [3:0] g, input logic [1:0] s,
                          input logic v, input logic t);
      vecs[i] = '{r, m, rq, d, g, s, v, t};
   endtask

   initial begin
      logic cur_mode;
      logic [3:0] cur_req;

      // fixed priority grant/done, request drop with another pending, RR rotation with wrap
      set_vec(0,  1, 0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
      set_vec(1,  0, 0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);
      set_vec(2,  0, 0, 4'b1010, 1, 4'b0000, 2'd1, 0, 0);
      set_vec(3,  0, 0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
      set_vec(4,  0, 0, 4'b0000, 0, 4'b0000, 2'd1, 0, 0);
      set_vec(5,  0, 0, 4'b1010, 0, 4'b0010, 2'd1, 1, 0);
      set_vec(6,  0, 0, 4'b1000, 0, 4'b0000, 2'd1, 0, 0);
      set_vec(7,  0, 0, 4'b1000, 0, 4'b0000, 2'd1, 0, 0);
      set_vec(8,  0, 0, 4'b1000, 0, 4'b1000, 2'd3, 1, 0);
      set_vec(9,  0, 0, 4'b1000, 1, 4'b0000, 2'd3, 0, 0);
      set_vec(10, 0, 0, 4'b0000, 0, 4'b0000, 2'd3, 0, 0);
      set_vec(11, 0, 1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      set_vec(12, 0, 1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      set_vec(13, 0, 1, 4'b1111, 0, 4'b0000, 2'd0, 0, 0);
      set_vec(14, 0, 1, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
      set_vec(15, 0, 1, 4'b1111, 1, 4'b0000, 2'd1, 0, 0);
      set_vec(16, 0, 1, 4'b1111, 0, 4'b0000, 2'd1, 0, 0);
      set_vec(17, 0, 1, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
      set_vec(18, 0, 1, 4'b1111, 1, 4'b0000, 2'd2, 0, 0);
      set_vec(19, 0, 1, 4'b1111, 0, 4'b0000, 2'd2, 0, 0);
      set_vec(20, 0, 1, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
      set_vec(21, 0, 1, 4'b1111, 1, 4'b0000, 2'd3, 0, 0);
      set_vec(22, 0, 1, 4'b1111, 0, 4'b0000, 2'd3, 0, 0);
      set_vec(23, 0, 1, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
      set_vec(24, 0, 1, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
      set_vec(25, 0, 1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);

      drive(1, 0, 4'b0000, 0);
      tick();
      for (int i = 0; i < 26; i++) begin
         drive(vecs[i].rst, vecs[i].mode, vecs[i].req, vecs[i].done);
         tick();
         check($sformatf("vec%0d", i), pack_outs(gnt, gnt_sel, gnt_valid, timeout_err),
               pack_outs(vecs[i].exp_gnt, vecs[i].exp_sel, vecs[i].exp_valid, vecs[i].exp_to));
      end

      // timeout: 8 granted cycles, then a single-cycle timeout_err
      drive(0, 0, 4'b0100, 0);
      for (int i = 0; i < MAX_HOLD; i++) begin
         tick();
         check_outs($sformatf("t3_hold%0d", i), 4'b0100, 2'd2, 1, 0);
      end
      tick();
      check_outs("t3_timeout", 4'b0000, 2'd2, 0, 1);
      drive(0, 0, 4'b0000, 0);
      tick();
      check_outs("t3_pulse_end", 4'b0000, 2'd2, 0, 0);

      // done arriving together with the last hold cycle releases without error
      drive(0, 0, 4'b0100, 0);
      tick();
      check_outs("t4_grant", 4'b0100, 2'd2, 1, 0);
      for (int i = 0; i < MAX_HOLD - 1; i++) begin
         tick();
         check_outs($sformatf("t4_hold%0d", i), 4'b0100, 2'd2, 1, 0);
      end
      drive(0, 0, 4'b0100, 1);
      tick();
      check_outs("t4_done_wins", 4'b0000, 2'd2, 0, 0);
      drive(0, 0, 4'b0000, 0);
      tick();
      check_outs("t4_no_err", 4'b0000, 2'd2, 0, 0);

      // reset during an RR grant of requester 2, then rr pointer restarts at 0
      drive(0, 1, 4'b0100, 0);
      tick();
      check_outs("t5_grant2", 4'b0100, 2'd2, 1, 0);
      drive(1, 1, 4'b0100, 0);
      tick();
      check_outs("t5_reset", 4'b0000, 2'd0, 0, 0);
      drive(0, 1, 4'b1111, 0);
      tick();
      check_outs("t5_after_rst", 4'b0001, 2'd0, 1, 0);

      // random traffic against the model
      cur_mode = 1'b0;
      cur_req  = 4'b0000;
      step(1, 0, 4'b0000, 0);
      for (int i = 0; i < 4000; i++) begin
         logic r;
         logic d;
         if ($urandom_range(0, 15) == 0) cur_mode = ~cur_mode;
         if ($urandom_range(0, 4) == 0) cur_req = 4'($urandom_range(0, 15));
         d = ($urandom_range(0, 9) == 0);
         r = ($urandom_range(0, 299) == 0);
         step(r, cur_mode, cur_req, d);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
